// File: rtl/npu_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : npu_frame_packer
//  Purpose  : NPU output stage. Packs interior-pixel results from a FWFT FIFO
//             into WORD_W-bit RAM words. It rebuilds the full raster frame by
//             inserting BORDER_VAL at every border position, then hands the
//             RAM read port to the host once the frame is complete.
//  Revision : 1.0 - initial release
// ============================================================================
module npu_frame_packer #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int BORDER     = 1,
   parameter int PIX_W      = 8,
   parameter int FIFO_W     = 32,
   parameter int WORD_W     = 64,
   parameter int ADDR_W     = 16,
   parameter int BORDER_VAL = 0
) (
   input  logic              clk,
   input  logic              reset,        // asynchronous, active-low
   input  logic              frame_start,
   input  logic              fifo_empty,
   input  logic [FIFO_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [WORD_W-1:0] ram_wdata,
   output logic              busy,
   output logic              frame_done
);

   // ------------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------------
   localparam int PPW = WORD_W / PIX_W;                      // pixels per word
   localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int LW  = (PPW   > 1) ? $clog2(PPW)   : 1;

   localparam logic [XW-1:0]    X_LAST    = XW'(IMG_W - 1);
   localparam logic [YW-1:0]    Y_LAST    = YW'(IMG_H - 1);
   localparam logic [LW-1:0]    LANE_LAST = LW'(PPW - 1);
   localparam logic [PIX_W-1:0] BVAL      = PIX_W'(BORDER_VAL);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter sanity checks
   // ------------------------------------------------------------------------
   generate
      if ((WORD_W % PIX_W) != 0) begin : g_chk_word
         $error("npu_frame_packer: WORD_W must be a multiple of PIX_W");
      end
      if ((IMG_W % PPW) != 0) begin : g_chk_width
         $error("npu_frame_packer: IMG_W must be a multiple of WORD_W/PIX_W");
      end
      if (FIFO_W < PIX_W) begin : g_chk_fifo
         $error("npu_frame_packer: FIFO_W must be >= PIX_W");
      end
      if (2 * BORDER > IMG_W || 2 * BORDER > IMG_H) begin : g_chk_border
         $error("npu_frame_packer: BORDER too thick for the frame");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [XW-1:0]       x_q, x_d;
   logic [YW-1:0]       y_q, y_d;
   logic [LW-1:0]       lane_q, lane_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [WORD_W-1:0]   pack_q, pack_d;       // word being assembled
   logic [WORD_W-1:0]   wdata_q, wdata_d;     // completed word awaiting write
   logic                wr_pend_q, wr_pend_d; // completed word is written this cycle

   logic                w_border;
   logic                w_last_px;
   logic                w_accept;
   logic [PIX_W-1:0]    w_pix;
   logic                w_unused_fifo;

   // Only the low PIX_W bits of the FIFO head carry a pixel.
   assign w_unused_fifo = ^fifo_data;

   // ------------------------------------------------------------------------
   // Border classification of the current raster position
   // ------------------------------------------------------------------------
   generate
      if (BORDER > 0) begin : g_border
         localparam logic [XW-1:0] X_LO = XW'(BORDER);
         localparam logic [XW-1:0] X_HI = XW'(IMG_W - BORDER);
         localparam logic [YW-1:0] Y_LO = YW'(BORDER);
         localparam logic [YW-1:0] Y_HI = YW'(IMG_H - BORDER);
         assign w_border = (x_q < X_LO) | (x_q >= X_HI) |
                           (y_q < Y_LO) | (y_q >= Y_HI);
      end else begin : g_no_border
         assign w_border = 1'b0;
      end
   endgenerate

   assign w_last_px = (x_q == X_LAST) && (y_q == Y_LAST);

   // Next-state logic: raster walk, lane packing and word hand-off.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      lane_d     = lane_q;
      pack_d     = pack_q;
      wdata_d    = wdata_q;
      wr_pend_d  = 1'b0;
      waddr_d    = wr_pend_q ? (waddr_q + 1'b1) : waddr_q;
      fifo_rd_en = 1'b0;
      w_accept   = 1'b0;
      w_pix      = BVAL;

      case (state_q)
         S_IDLE, S_DONE: begin
            // A new frame restarts the raster and word address from zero;
            // queued FIFO entries are kept for it.
            if (frame_start) begin
               state_d = S_FILL;
               x_d     = '0;
               y_d     = '0;
               lane_d  = '0;
               waddr_d = '0;
               pack_d  = '0;
            end
         end

         S_FILL: begin
            if (w_border) begin
               w_accept = 1'b1;
               w_pix    = BVAL;
            end else if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               w_accept   = 1'b1;
               w_pix      = fifo_data[PIX_W-1:0];
            end

            if (w_accept) begin
               pack_d[lane_q*PIX_W +: PIX_W] = w_pix;

               // Last lane completes the word; its write goes out next cycle
               // from a separate register so packing can continue unbroken.
               if (lane_q == LANE_LAST) begin
                  lane_d    = '0;
                  wdata_d   = pack_d;
                  wr_pend_d = 1'b1;
               end else begin
                  lane_d = lane_q + 1'b1;
               end

               if (x_q == X_LAST) begin
                  x_d = '0;
                  y_d = w_last_px ? '0 : (y_q + 1'b1);
               end else begin
                  x_d = x_q + 1'b1;
               end

               if (w_last_px) begin
                  state_d = S_FLUSH;
               end
            end
         end

         S_FLUSH: begin
            // The final word is being written in this cycle.
            state_d = S_DONE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         lane_q    <= '0;
         waddr_q   <= '0;
         pack_q    <= '0;
         wdata_q   <= '0;
         wr_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         lane_q    <= lane_d;
         waddr_q   <= waddr_d;
         pack_q    <= pack_d;
         wdata_q   <= wdata_d;
         wr_pend_q <= wr_pend_d;
      end
   end

   // Output decode: RAM port belongs to the host only once the frame is done.
   always_comb begin
      ram_we     = wr_pend_q;
      ram_wdata  = wdata_q;
      busy       = (state_q == S_FILL) || (state_q == S_FLUSH);
      frame_done = (state_q == S_DONE);
      case (state_q)
         S_DONE:  ram_addr = rd_addr;
         S_IDLE:  ram_addr = '0;
         default: ram_addr = waddr_q;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_npu_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_npu_frame_packer
//  Purpose  : Self-checking bench for npu_frame_packer (8x4 frame, 1-px
//             border, 8-bit pixels, 32-bit words). Expected RAM writes are
//             queued when a frame is launched and compared as they appear.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_npu_frame_packer;

   localparam int IMG_W  = 8;
   localparam int IMG_H  = 4;
   localparam int BORDER = 1;
   localparam int PIX_W  = 8;
   localparam int FIFO_W = 32;
   localparam int WORD_W = 32;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              frame_start;
   logic              fifo_empty = 1'b1;
   logic [FIFO_W-1:0] fifo_data  = '0;
   logic              fifo_rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [WORD_W-1:0] ram_wdata;
   logic              busy;
   logic              frame_done;

   npu_frame_packer #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER(BORDER), .PIX_W(PIX_W),
      .FIFO_W(FIFO_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .BORDER_VAL(0)
   ) u_dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
      .rd_addr(rd_addr), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [7:0]  pix_q[$];
   logic [31:0] mem[16];
   int          wr_cnt[16];
   int          wr_total = 0;
   int          n_vec    = 0;
   int          n_err    = 0;
   int          pops     = 0;
   int          cyc      = 0;
   bit          throttle = 1'b0;
   bit          pop_pend = 1'b0;

   // Compare one observed value against its expectation.
   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference raster: border pixels are 0, interior pixels count up from first.
   task automatic push_exp(input logic [7:0] first);
      logic [31:0] w;
      logic [7:0]  p;
      logic [7:0]  pix;
      int          lane;
      int          a;
      w = '0; p = first; lane = 0; a = 0;
      for (int y = 0; y < IMG_H; y++) begin
         for (int x = 0; x < IMG_W; x++) begin
            if (x < BORDER || x >= IMG_W - BORDER || y < BORDER || y >= IMG_H - BORDER) begin
               pix = 8'h00;
            end else begin
               pix = p;
               p++;
            end
            w[lane*8 +: 8] = pix;
            lane++;
            if (lane == 4) begin
               exp_q.push_back('{addr: ADDR_W'(a), data: w});
               a++;
               lane = 0;
            end
         end
      end
   endtask

   task automatic push_pix(input logic [7:0] first);
      for (int i = 0; i < 12; i++) begin
         pix_q.push_back(first + 8'(i));
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 16; i++) wr_cnt[i] = 0;
      wr_total = 0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400; i++) begin
         if (frame_done) break;
         @(posedge clk); #1;
      end
      check_val("frame_done_timeout", {63'd0, frame_done}, 64'd1);
   endtask

   // Write monitor / scoreboard, plus FIFO pop sampling away from the edge.
   always @(negedge clk) begin
      pop_pend = fifo_rd_en;
      if (ram_we) begin
         if (exp_q.size() == 0) begin
            check_val("spurious_we", {63'd0, ram_we}, 64'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check_val("wr_addr", 64'(ram_addr), 64'(e.addr));
            check_val("wr_data", 64'(ram_wdata), 64'(e.data));
         end
         mem[ram_addr] = ram_wdata;
         wr_cnt[ram_addr]++;
         wr_total++;
      end
   end

   // First-word-fall-through FIFO model, optionally limited to 1 px per 3 cycles.
   always @(posedge clk) begin
      #2;
      if (pop_pend && pix_q.size() > 0) begin
         void'(pix_q.pop_front());
         pops++;
      end
      cyc++;
      fifo_empty = (pix_q.size() == 0) || (throttle && (cyc % 3 != 0));
      fifo_data  = (pix_q.size() > 0) ? {24'h0, pix_q[0]} : '0;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      reset = 1'b0; frame_start = 1'b0; rd_addr = '0;
      clear_counts();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ram_we",     {63'd0, ram_we},     64'd0);
      check_val("rst_ram_addr",   64'(ram_addr),       64'd0);
      check_val("rst_ram_wdata",  64'(ram_wdata),      64'd0);
      check_val("rst_busy",       {63'd0, busy},       64'd0);
      check_val("rst_frame_done", {63'd0, frame_done}, 64'd0);
      check_val("rst_fifo_rd_en", {63'd0, fifo_rd_en}, 64'd0);
      reset = 1'b1;

      // Preloaded FIFO, full-rate frame.
      push_pix(8'h01); push_exp(8'h01);
      pulse_start();
      wait_done();
      check_val("t1_wr_total", 64'(wr_total), 64'd8);
      check_val("t1_exp_left", 64'(exp_q.size()), 64'd0);
      check_val("t1_addr0", 64'(mem[0]), 64'h0000_0000);
      check_val("t1_addr2", 64'(mem[2]), 64'h0302_0100);
      check_val("t1_addr3", 64'(mem[3]), 64'h0006_0504);
      check_val("t1_addr7", 64'(mem[7]), 64'h0000_0000);
      check_val("t1_busy",  {63'd0, busy}, 64'd0);

      // Host read port in DONE.
      rd_addr = 4'd5;
      #1;
      check_val("t4_ram_addr", 64'(ram_addr), 64'd5);
      check_val("t4_ram_we",   {63'd0, ram_we}, 64'd0);

      // Second frame with a slow FIFO; same image, each word written once.
      clear_counts();
      throttle = 1'b1;
      push_pix(8'h01); push_exp(8'h01);
      pulse_start();
      check_val("t4_busy_after_start", {63'd0, busy}, 64'd1);
      wait_done();
      throttle = 1'b0;
      check_val("t2_wr_total", 64'(wr_total), 64'd8);
      for (int a = 0; a < 8; a++) begin
         check_val($sformatf("t2_wr_once_%0d", a), 64'(wr_cnt[a]), 64'd1);
      end

      // Empty FIFO: border row is written, then the raster stalls at (1,1).
      clear_counts();
      push_exp(8'h20);
      pulse_start();
      repeat (30) @(posedge clk);
      #1;
      check_val("t3_wr_total", 64'(wr_total), 64'd2);
      check_val("t3_wr_cnt0",  64'(wr_cnt[0]), 64'd1);
      check_val("t3_wr_cnt1",  64'(wr_cnt[1]), 64'd1);
      check_val("t3_rd_en",    {63'd0, fifo_rd_en}, 64'd0);
      check_val("t3_busy",     {63'd0, busy}, 64'd1);
      push_pix(8'h20);
      wait_done();
      check_val("t3_wr_total_end", 64'(wr_total), 64'd8);

      // Reset while the 7th interior pixel is being offered.
      clear_counts();
      push_pix(8'h40); push_exp(8'h40);
      base = pops;
      pulse_start();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pops - base >= 6) break;
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fifo_rd_en) break;
      end
      check_val("t5_rd_en_7th", {63'd0, fifo_rd_en}, 64'd1);
      reset = 1'b0;
      #1;
      check_val("t5_ram_we",     {63'd0, ram_we},     64'd0);
      check_val("t5_fifo_rd_en", {63'd0, fifo_rd_en}, 64'd0);
      check_val("t5_busy",       {63'd0, busy},       64'd0);
      check_val("t5_ram_addr",   64'(ram_addr),       64'd0);
      check_val("t5_ram_wdata",  64'(ram_wdata),      64'd0);
      check_val("t5_wr_before",  64'(wr_total),       64'd4);
      exp_q.delete();
      pix_q.delete();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check_val("t5_wr_after",    64'(wr_total),       64'd4);
      check_val("t5_idle_busy",   {63'd0, busy},       64'd0);
      check_val("t5_idle_done",   {63'd0, frame_done}, 64'd0);

      // Recovery frame from IDLE.
      clear_counts();
      push_pix(8'h60); push_exp(8'h60);
      pulse_start();
      wait_done();
      check_val("t6_wr_total", 64'(wr_total), 64'd8);
      check_val("t6_exp_left", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
